d_factor_shift_arbiter: RTL and testbench
=========================================

// Module: d_factor_shift_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one registered 32-bit right-shift scaler (shift_reg) among N_REQ requesters.
//  Sits in the adaptive-threshold D-factor path; each threshold channel asks for energy>>a and receives the result.
//  One operation in flight at a time; valid/ready handshakes on request and response sides.
// PARAMETERS
//  N_REQ  4   number of requesters (2..8)
//  DW     32  data width; fixed to shifter width
//  SW     5   shift-amount width; fixed, equal to log2(DW)
// PORTS
//  clk        in   1         system clock, rising edge
//  sclr_n     in   1         asynchronous active-low reset
//  req_valid  in   N_REQ     request valid, one bit per requester
//  req_ready  out  N_REQ     request accepted (one-hot or zero)
//  req_shift  in   SW*N_REQ  shift amount; requester i owns bits [SW*i +: SW]
//  req_data   in   DW*N_REQ  operand; requester i owns bits [DW*i +: DW]
//  resp_valid out  N_REQ     result valid for the granted requester (one-hot or zero)
//  resp_ready in   N_REQ     result consumed; only the bit matching resp_valid is used
//  resp_data  out  DW        shared result bus
//  busy       out  1         high whenever state != IDLE
//  sh_sclr    out  1         drives shifter sclr
//  sh_a       out  SW        drives shifter a
//  sh_d       out  DW        drives shifter d
//  sh_q       in   DW        shifter q (registered, 1-cycle latency)
// BEHAVIOUR
//  Reset (sclr_n=0, async):
//   - state=IDLE, RR pointer=N_REQ-1; req_ready, resp_valid, resp_data, sh_a, sh_d, busy = 0.
//   - sh_sclr = 1; it clears on the first clk edge after sclr_n deasserts.
//  FSM states: IDLE -> SHIFT -> CAPT -> RESP -> IDLE.
//  IDLE:
//   - Winner g = first i with req_valid[i], searching from ptr+1 upward with wrap.
//   - req_ready[g] = 1 combinationally in the same cycle; transfer occurs in that cycle T.
//   - At the end of T: sh_a<=req_shift[g], sh_d<=req_data[g], ptr<=g, state<=SHIFT.
//   - No valid request: stay in IDLE with all req_ready = 0.
//  SHIFT (T+1): shifter samples sh_a/sh_d; state<=CAPT.
//  CAPT (T+2): resp_data<=sh_q; state<=RESP.
//  RESP (T+3 onward):
//   - resp_valid[g]=1; resp_data held stable until resp_ready[g]=1 in the same cycle.
//   - On that handshake: resp_valid<=0, state<=IDLE.
//   - resp_ready on any other bit is ignored.
//  Handshake rules:
//   - req_ready is 0 in every state except IDLE.
//   - Next accept is no earlier than the cycle after the RESP handshake; best-case throughput 1 op / 4 cycles.
//  Fairness: a requester holding valid waits at most N_REQ-1 operations.
//  Boundaries:
//   - Requester that just completed has lowest priority next time.
//   - ptr wraps from N_REQ-1 to 0.
//   - sh_a/sh_d are held after issue and are not cleared at RESP.
//   - A shift of 0 returns the operand unchanged; a shift of 31 returns the operand's bit 31.
//   - Reset asserted mid-operation: the in-flight result is discarded; no resp_valid pulse; ptr returns to N_REQ-1.
//  busy is registered and equals (state != IDLE).
// TESTING
//  1 Hold sclr_n=0 -> all outputs 0 and sh_sclr=1; release -> sh_sclr=0 after 1 edge, busy=0.
//  2 Only req0: data 0x8000_0000, shift 4, accepted in cycle T -> resp_valid[0] at T+3, resp_data=0x0800_0000.
//  3 All 4 valid, data 0xFFFF_FFFF, shifts 1/2/3/4 -> service order 0,1,2,3;
//    results 0x7FFF_FFFF, 0x3FFF_FFFF, 0x1FFF_FFFF, 0x0FFF_FFFF.
//  4 resp_ready low for 5 cycles in RESP -> resp_data stable, req_ready=0, busy=1; completes on resp_ready=1.
//  5 Edge shifts on 0xFFFF_FFFF: shift 0 -> 0xFFFF_FFFF; shift 31 -> 0x0000_0001.
//  6 sclr_n pulsed low in CAPT -> no resp_valid; next request from req0 and req2 together -> req0 granted first.

Source files
------------

// File: rtl/d_factor_shift_arbiter.sv
// d_factor_shift_arbiter
//   Round-robin sequencer that shares one registered right-shift scaler among
//   N_REQ threshold channels. Each channel asks for data >> shift and gets the
//   result back on a shared bus. Only one operation is in flight at a time.
//
// Ports
//   clk, sclr_n           clock (rising edge), async active-low reset
//   req_valid/req_ready   per-requester request handshake (ready one-hot or 0)
//   req_shift, req_data   packed per-requester shift amount and operand
//   resp_valid/resp_ready per-requester response handshake (valid one-hot or 0)
//   resp_data             shared result bus, held until the response handshake
//   busy                  registered, high whenever the FSM is not idle
//   sh_sclr, sh_a, sh_d   drive the external shifter (clear, amount, operand)
//   sh_q                  external shifter output, one cycle after sh_a/sh_d
//
// state | meaning
// IDLE  | arbitrate; grant the winner combinationally and latch its operands
// SHIFT | shifter samples sh_a/sh_d
// CAPT  | sh_q is valid; capture it into resp_data
// RESP  | present resp_valid to the granted requester until resp_ready
module d_factor_shift_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 32,
  parameter int SW    = 5
) (
  input  logic                clk,
  input  logic                sclr_n,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [SW*N_REQ-1:0] req_shift,
  input  logic [DW*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]    resp_valid,
  input  logic [N_REQ-1:0]    resp_ready,
  output logic [DW-1:0]       resp_data,
  output logic                busy,
  output logic                sh_sclr,
  output logic [SW-1:0]       sh_a,
  output logic [DW-1:0]       sh_d,
  input  logic [DW-1:0]       sh_q
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] sh_a_q, sh_a_d;
  logic [DW-1:0] sh_d_q, sh_d_d;
  logic [DW-1:0] resp_data_q, resp_data_d;
  logic          busy_q, busy_d;
  logic          sh_sclr_q;

  logic          found;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   cand;

  // Search starts one past the last winner so it has lowest priority next.
  // cand is one bit wider so ptr+k never overflows before the wrap compare.
  always_comb begin
    found   = 1'b0;
    gnt_idx = ptr_q;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_REQ)) begin
        cand = cand - (PW+1)'(N_REQ);
      end
      if (!found && req_valid[cand[PW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sh_a_d      = sh_a_q;
    sh_d_d      = sh_d_q;
    resp_data_d = resp_data_q;
    req_ready   = '0;
    resp_valid  = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[gnt_idx] = 1'b1;
          sh_a_d             = req_shift[SW*gnt_idx +: SW];
          sh_d_d             = req_data[DW*gnt_idx +: DW];
          ptr_d              = gnt_idx;
          state_d            = SHIFT;
        end
      end
      SHIFT: state_d = CAPT;
      CAPT: begin
        resp_data_d = sh_q;
        state_d     = RESP;
      end
      RESP: begin
        resp_valid[ptr_q] = 1'b1;
        if (resp_ready[ptr_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      state_q     <= IDLE;
      ptr_q       <= PW'(N_REQ-1);
      sh_a_q      <= '0;
      sh_d_q      <= '0;
      resp_data_q <= '0;
      busy_q      <= 1'b0;
      sh_sclr_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sh_a_q      <= sh_a_d;
      sh_d_q      <= sh_d_d;
      resp_data_q <= resp_data_d;
      busy_q      <= busy_d;
      sh_sclr_q   <= 1'b0;
    end
  end

  assign resp_data = resp_data_q;
  assign busy      = busy_q;
  assign sh_sclr   = sh_sclr_q;
  assign sh_a      = sh_a_q;
  assign sh_d      = sh_d_q;

endmodule

// File: tb/tb_d_factor_shift_arbiter.sv
// tb_d_factor_shift_arbiter
//   Random and directed stimulus against a transaction-level model of the
//   arbiter. Accepted requests push their expected result into a queue; a
//   separate monitor pops and compares whenever a response is presented.
module tb_d_factor_shift_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 5;

  logic            clk;
  logic            sclr_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [SW*N-1:0] req_shift;
  logic [DW*N-1:0] req_data;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready;
  logic [DW-1:0]   resp_data;
  logic            busy;
  logic            sh_sclr;
  logic [SW-1:0]   sh_a;
  logic [DW-1:0]   sh_d;
  logic [DW-1:0]   sh_q;

  d_factor_shift_arbiter #(.N_REQ(N), .DW(DW), .SW(SW)) dut (
    .clk(clk), .sclr_n(sclr_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_shift(req_shift), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy), .sh_sclr(sh_sclr), .sh_a(sh_a), .sh_d(sh_d), .sh_q(sh_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External registered shifter.
  always @(posedge clk) begin
    if (sh_sclr) sh_q <= '0;
    else         sh_q <= sh_d >> sh_a;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          g;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  int          grant_log[$];
  int          checks = 0;
  int          errors = 0;

  logic [N-1:0] pend = '0;
  logic [N-1:0] acc_flag = '0;
  logic [31:0]  pdata [N];
  logic [4:0]   pshift [N];
  bit           gen_random = 0;
  int           hold = 0;
  bit           m_busy = 0;
  int           m_g = 0;
  int           m_acc = 0;
  int           mptr = N-1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        if (r != -1) return -2;
        r = i;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] s);
    pend[i]   = 1'b1;
    pdata[i]  = d;
    pshift[i] = s;
  endtask

  // One clock cycle: drive inputs after the falling edge, then check the
  // combinational and registered outputs against the model before the rising edge.
  task automatic step();
    logic [N-1:0] rr;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] one;
    int w;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (acc_flag[i]) begin
        pend[i]     = 1'b0;
        acc_flag[i] = 1'b0;
      end
    end
    if (gen_random) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) set_req(i, rand_data(), 5'($urandom_range(0, 31)));
      end
    end
    req_valid = pend;
    for (int i = 0; i < N; i++) begin
      req_data[DW*i +: DW]  = pend[i] ? pdata[i] : $urandom;
      req_shift[SW*i +: SW] = pend[i] ? pshift[i] : 5'($urandom);
    end
    rr = N'($urandom);
    if (m_busy && cyc >= m_acc + 3) begin
      if (hold > 0) begin
        rr[m_g] = 1'b0;
        hold--;
      end else if (!gen_random) begin
        rr[m_g] = 1'b1;
      end
    end
    resp_ready = rr;
    #1;
    one = 1;
    if (!m_busy) begin
      chk("busy_idle", busy, 0);
      w = rr_pick(pend, mptr);
      exp_rdy = (w >= 0) ? (one << w) : '0;
      chk("req_ready", req_ready, exp_rdy);
      if (w >= 0) begin
        sb_q.push_back('{g: w, data: pdata[w] >> pshift[w], acc: cyc});
        grant_log.push_back(onehot_idx(req_ready));
        m_busy      = 1;
        m_g         = w;
        m_acc       = cyc;
        mptr        = w;
        acc_flag[w] = 1'b1;
      end
    end else begin
      chk("req_ready_busy", req_ready, 0);
      chk("busy_active", busy, 1);
      if (cyc >= m_acc + 3 && resp_ready[m_g]) m_busy = 0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || pend != 0 || acc_flag != 0) && n < 300) begin
      step();
      n++;
    end
    chk("drain_timeout", (n < 300), 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_data"}, resp_data, 0);
    chk({tag, "_sh_a"}, sh_a, 0);
    chk({tag, "_sh_d"}, sh_d, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sh_sclr"}, sh_sclr, 1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    sclr_n     = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    req_data   = '0;
    req_shift  = '0;
    pend       = '0;
    acc_flag   = '0;
    hold       = 0;
    sb_q.delete();
    m_busy     = 0;
    mptr       = N-1;
    #1 chk_reset_outs("rst_assert");
    repeat (2) @(negedge clk);
    #1 chk_reset_outs("rst_hold");
    @(negedge clk);
    sclr_n = 1'b1;
    #1 chk("sh_sclr_release", sh_sclr, 1);
    @(negedge clk);
    #1;
    chk("sh_sclr_after_edge", sh_sclr, 0);
    chk("busy_after_reset", busy, 0);
  endtask

  // Response monitor: expects resp_valid exactly from accept+3 until the handshake.
  initial begin
    logic [N-1:0] exp_rv;
    logic [N-1:0] one;
    one = 1;
    forever begin
      @(negedge clk);
      #2;
      exp_rv = '0;
      if (sb_q.size() > 0 && cyc >= sb_q[0].acc + 3) exp_rv = one << sb_q[0].g;
      chk("resp_valid", resp_valid, exp_rv);
      if (exp_rv != 0) begin
        chk("resp_data", resp_data, sb_q[0].data);
        if (resp_ready[sb_q[0].g]) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    sclr_n     = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    req_data   = '0;
    req_shift  = '0;

    reset_dut();

    // All four at once from reset: service order 0,1,2,3.
    grant_log.delete();
    for (int i = 0; i < N; i++) set_req(i, 32'hFFFF_FFFF, 5'(i + 1));
    wait_idle();
    chk("order_count", grant_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) chk("order_entry", grant_log[i], i);
    end

    // Single requester, 0x8000_0000 >> 4.
    set_req(0, 32'h8000_0000, 5'd4);
    wait_idle();

    // Stalled response with other requesters waiting.
    hold = 5;
    set_req(1, 32'h1234_5678, 5'd3);
    set_req(2, 32'hCAFE_F00D, 5'd7);
    wait_idle();

    // Edge shift amounts.
    set_req(1, 32'hFFFF_FFFF, 5'd0);
    set_req(3, 32'hFFFF_FFFF, 5'd31);
    wait_idle();

    // Reset during CAPT, then req0 and req2 together.
    set_req(1, 32'hDEAD_BEEF, 5'd2);
    step();
    step();
    reset_dut();
    grant_log.delete();
    set_req(0, 32'h0000_F000, 5'd8);
    set_req(2, 32'hF000_0000, 5'd28);
    wait_idle();
    chk("post_reset_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // Random traffic.
    gen_random = 1;
    repeat (1500) step();
    gen_random = 0;
    wait_idle();
    repeat (4) step();
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
